// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter.
//   state_e       FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W   width of one BCD digit
//   ADJ_SUB       correction subtrahend applied to a digit >= ADJ_THRESH
//   ADJ_THRESH    correction threshold
//   N_BITS_DEF    default binary width / iteration count (only 8 supported)
//   bcd_invalid() range check used when BCD2BIN_CHECK_EN is defined
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADJ_SUB     = 4'd3;
    localparam logic [3:0]  ADJ_THRESH  = 4'd8;
    localparam int unsigned N_BITS_DEF  = 8;

    // True when the triple lies outside 0..255 or holds a non-decimal digit.
    function automatic logic bcd_invalid(input logic [1:0] h, input logic [3:0] t,
                                         input logic [3:0] o);
        logic [7:0] tail;
        tail = ({4'd0, t} * 8'd10) + {4'd0, o};
        return (t > 4'd9) || (o > 4'd9) || (h == 2'd3) || ((h == 2'd2) && (tail > 8'd55));
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: request/result bundle of the BCD-to-binary converter.
//   start, HUNDREDS, TENS, ONES  request side (driven by master)
//   busy, done, bin, err         result side (driven by slave)
interface bcd_to_binary_if;
    logic       start;
    logic [1:0] HUNDREDS;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic       busy;
    logic       done;
    logic [7:0] bin;
    logic       err;

    modport master (
        output start, HUNDREDS, TENS, ONES,
        input  busy, done, bin, err
    );

    modport slave (
        input  start, HUNDREDS, TENS, ONES,
        output busy, done, bin, err
    );
endinterface

// File: rtl/sub3.sv
// sub3: reverse double-dabble digit correction, counterpart of add3.
//   digit     4-bit BCD digit after the right shift
//   adjusted  digit - 3 when digit >= 8, else digit unchanged
module sub3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);
    // No borrow possible: subtraction only happens for digit >= 8.
    assign adjusted = (digit >= ADJ_THRESH) ? (digit - ADJ_SUB) : digit;
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential 3-digit BCD to 8-bit binary converter using
// reverse double-dabble (shift right, then subtract 3 from digits >= 8),
// one shift per cycle over N_BITS cycles.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   slave side of bcd_to_binary_if (start/digits in, busy/done/bin/err out)
// Optional macro BCD2BIN_CHECK_EN: range-check the captured triple, report it on
// err with done and force bin to zero for invalid input. Undefined: err is 0.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int unsigned N_BITS = N_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    bcd_to_binary_if.slave      bus
);
    localparam int unsigned BCD_W = 2 + 2 * BCD_DIGIT_W;

    state_e              state_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [N_BITS-1:0]   binsr_q;
    logic [N_BITS-1:0]   bin_q;
    logic [2:0]          cnt_q;
    logic                busy_q;
    logic                done_q;

    logic [BCD_W+N_BITS-1:0] shifted;
    logic [BCD_DIGIT_W-1:0]  tens_adj;
    logic [BCD_DIGIT_W-1:0]  ones_adj;
    logic [BCD_W-1:0]        bcd_next;
    logic [N_BITS-1:0]       binsr_next;

    assign shifted = {bcd_q, binsr_q} >> 1;

    sub3 u_sub3_tens (
        .digit    (shifted[N_BITS+2*BCD_DIGIT_W-1:N_BITS+BCD_DIGIT_W]),
        .adjusted (tens_adj)
    );

    sub3 u_sub3_ones (
        .digit    (shifted[N_BITS+BCD_DIGIT_W-1:N_BITS]),
        .adjusted (ones_adj)
    );

    // Hundreds field is at most 2 and can never reach the threshold.
    assign bcd_next   = {shifted[BCD_W+N_BITS-1:N_BITS+2*BCD_DIGIT_W], tens_adj, ones_adj};
    assign binsr_next = shifted[N_BITS-1:0];

`ifdef BCD2BIN_CHECK_EN
    logic err_cap_q;
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cap_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            err_cap_q <= bcd_invalid(bus.HUNDREDS, bus.TENS, bus.ONES);
        end else if (state_q == SHIFT && cnt_q == 3'd0) begin
            err_q <= err_cap_q;
        end
    end

    assign bus.err = err_q;
`else
    logic err_cap_q;
    assign err_cap_q = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            binsr_q <= '0;
            bin_q   <= '0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bcd_q   <= {bus.HUNDREDS, bus.TENS, bus.ONES};
                        binsr_q <= '0;
                        cnt_q   <= 3'd7;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q   <= bcd_next;
                    binsr_q <= binsr_next;
                    if (cnt_q == 3'd0) begin
                        // Result is loaded on the final shift edge so it is
                        // presented together with done in the DONE cycle.
                        bin_q   <= err_cap_q ? '0 : binsr_next;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bin  = bin_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: self-checking bench for bcd_to_binary. Expected results
// come from decimal arithmetic (100*h + 10*t + o) and digit splitting.
module tb_bcd_to_binary;
    logic clk;
    logic rst;

    bcd_to_binary_if bus ();

    bcd_to_binary #(.N_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] dig_h(input int v);
        return 2'(v / 100);
    endfunction
    function automatic logic [3:0] dig_t(input int v);
        return 4'((v / 10) % 10);
    endfunction
    function automatic logic [3:0] dig_o(input int v);
        return 4'(v % 10);
    endfunction

    // Launch one conversion and follow it to the return to IDLE.
    task automatic run_conv(input string tag, input logic [1:0] h, input logic [3:0] t,
                            input logic [3:0] o, input logic [7:0] exp_bin,
                            input logic exp_err, input bit chk_bin, input bit timing);
        int lat;
        @(negedge clk);
        bus.HUNDREDS = h;
        bus.TENS     = t;
        bus.ONES     = o;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        // Inputs are not sampled after capture.
        bus.HUNDREDS = ~h;
        bus.TENS     = ~t;
        bus.ONES     = ~o;
        if (timing) check_eq({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (timing && !bus.done) check_eq({tag, ".busy_mid"}, 32'(bus.busy), 32'd1);
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'd8);
        if (timing) check_eq({tag, ".busy_e8"}, 32'(bus.busy), 32'd1);
        if (chk_bin) check_eq({tag, ".bin"}, 32'(bus.bin), 32'(exp_bin));
        check_eq({tag, ".err"}, 32'(bus.err), 32'(exp_err));
        @(posedge clk);
        #1;
        check_eq({tag, ".done_e9"}, 32'(bus.done), 32'd0);
        if (timing) check_eq({tag, ".busy_e9"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int v;
        int dones;
        int lat;
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.HUNDREDS = 2'd0;
        bus.TENS     = 4'd0;
        bus.ONES     = 4'd0;
        #12;
        check_eq("rst.busy", 32'(bus.busy), 32'd0);
        check_eq("rst.done", 32'(bus.done), 32'd0);
        check_eq("rst.bin", 32'(bus.bin), 32'd0);
        check_eq("rst.err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv("zero", 2'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        run_conv("v255", 2'd2, 4'd5, 4'd5, 8'd255, 1'b0, 1'b1, 1'b1);
        run_conv("v128", 2'd1, 4'd2, 4'd8, 8'd128, 1'b0, 1'b1, 1'b1);

        // Loopback: binary -> decimal digits -> converter -> binary.
        for (int i = 0; i < 256; i++) begin
            run_conv("loop", dig_h(i), dig_t(i), dig_o(i), 8'(i), 1'b0, 1'b1, 1'b0);
        end

        for (int k = 0; k < 40; k++) begin
            v = int'($urandom_range(0, 255));
            run_conv("rand", dig_h(v), dig_t(v), dig_o(v), 8'(v), 1'b0, 1'b1, 1'b0);
        end

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        bus.HUNDREDS = 2'd0;
        bus.TENS     = 4'd4;
        bus.ONES     = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.TENS  = 4'd9;
        bus.ONES  = 4'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        lat   = 3;
        for (int c = 0; c < 25; c++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    check_eq("ign.latency", 32'(lat), 32'd8);
                    check_eq("ign.bin", 32'(bus.bin), 32'd42);
                end
            end
            @(posedge clk);
            #1;
            if (dones == 0) lat++;
        end
        check_eq("ign.done_count", 32'(dones), 32'd1);

        // Reset during SHIFT aborts with no done pulse.
        @(negedge clk);
        bus.HUNDREDS = 2'd1;
        bus.TENS     = 4'd0;
        bus.ONES     = 4'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort.busy", 32'(bus.busy), 32'd0);
        check_eq("abort.done", 32'(bus.done), 32'd0);
        check_eq("abort.bin", 32'(bus.bin), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check_eq("abort.no_done", 32'(dones), 32'd0);
        run_conv("after_abort", 2'd0, 4'd0, 4'd7, 8'd7, 1'b0, 1'b1, 1'b0);

`ifdef BCD2BIN_CHECK_EN
        run_conv("chk_t10", 2'd0, 4'd10, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        run_conv("chk_256", 2'd2, 4'd5, 4'd6, 8'd0, 1'b1, 1'b1, 1'b0);
        run_conv("chk_h3", 2'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        run_conv("chk_255", 2'd2, 4'd5, 4'd5, 8'd255, 1'b0, 1'b1, 1'b0);
`else
        // Without the check, err stays low and bin is unspecified.
        run_conv("nochk_t10", 2'd0, 4'd10, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_conv("nochk_256", 2'd2, 4'd5, 4'd6, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
